// File: rtl/sdram_device_model.sv
// rtl/sdram_device_model.sv - SDR SDRAM command-bus responder with reduced array
// Tracks init, CAS latency, per-bank rows and timing; records the first protocol violation.
module sdram_device_model #(
  parameter int MEM_ROW_BITS = 3,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 4,
  parameter int REFRESH_MAX  = 800
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cke,
  input  logic        i_cs_n,
  input  logic        i_ras_n,
  input  logic        i_cas_n,
  input  logic        i_we_n,
  input  logic [1:0]  i_ba,
  input  logic [10:0] i_addr,
  input  logic [3:0]  i_dm,
  input  logic [31:0] i_dq_i,
  output logic [31:0] o_dq_o,
  output logic        o_dq_oe,
  output logic        o_ready,
  output logic        o_err,
  output logic [3:0]  o_err_code
);
  localparam int DEPTH = 4 * (2 ** MEM_ROW_BITS) * 256;
  localparam int IW    = 2 + MEM_ROW_BITS + 8;
  localparam int AGE_W = 8;
  localparam int RW    = $clog2(REFRESH_MAX + 2);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);
  localparam logic [AGE_W-1:0] RCD_A   = AGE_W'(T_RCD);
  localparam logic [AGE_W-1:0] RP_A    = AGE_W'(T_RP);
  localparam logic [AGE_W-1:0] RFC_A   = AGE_W'(T_RFC);
  localparam logic [RW-1:0]    REF_MAX = RW'(REFRESH_MAX);

  typedef enum logic [2:0] {
    ST_WAIT_PRE, ST_WAIT_REF1, ST_WAIT_REF2, ST_WAIT_MRS, ST_READY
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]             r_mem [DEPTH];
  logic [3:0]              r_bank_act;
  logic [MEM_ROW_BITS-1:0] r_open_row [4];
  logic [AGE_W-1:0]        r_act_age [4];
  logic [AGE_W-1:0]        r_pre_age [4];
  logic [AGE_W-1:0]        r_rfc_age;
  logic [RW-1:0]           r_ref_cnt;
  logic [1:0]              r_cl;
  logic [3:1]              r_pv;
  logic [31:0]             r_pd [1:3];

  logic          w_cmd_en, w_act, w_rd, w_wr, w_pre, w_ref, w_mrs, w_any, w_rw;
  logic [2:0]    w_cmd, w_mrs_cl;
  logic          w_cl_ok, w_pre_recent;
  logic [IW-1:0] w_idx;
  logic [10:1]   w_viol;
  logic [3:0]    w_code;
  logic          w_unused;

  // Reset masks the bus so nothing, including array writes, executes while it is held.
  assign w_cmd_en = i_cke & ~i_cs_n & ~i_rst;
  assign w_cmd    = {i_ras_n, i_cas_n, i_we_n};
  assign w_act    = w_cmd_en && (w_cmd == 3'b011);
  assign w_rd     = w_cmd_en && (w_cmd == 3'b101);
  assign w_wr     = w_cmd_en && (w_cmd == 3'b100);
  assign w_pre    = w_cmd_en && (w_cmd == 3'b010);
  assign w_ref    = w_cmd_en && (w_cmd == 3'b001);
  assign w_mrs    = w_cmd_en && (w_cmd == 3'b000);
  assign w_any    = w_act | w_rd | w_wr | w_pre | w_ref | w_mrs;
  assign w_rw     = w_rd | w_wr;
  assign w_mrs_cl = i_addr[6:4];
  assign w_cl_ok  = (w_mrs_cl == 3'd2) || (w_mrs_cl == 3'd3);
  assign w_idx    = {i_ba, r_open_row[i_ba], i_addr[7:0]};
  assign o_ready  = (r_state == ST_READY);
  assign w_unused = ^i_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_WAIT_PRE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_PRE:  if (w_pre && i_addr[10]) w_state_nxt = ST_WAIT_REF1;
      ST_WAIT_REF1: if (w_ref) w_state_nxt = ST_WAIT_REF2;
      ST_WAIT_REF2: if (w_ref) w_state_nxt = ST_WAIT_MRS;
      ST_WAIT_MRS:  if (w_mrs) w_state_nxt = ST_READY;
      default:      w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    w_pre_recent = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (r_pre_age[b] < RP_A) w_pre_recent = 1'b1;
    end
    w_viol     = '0;
    w_viol[1]  = (w_act | w_rw) && (r_state != ST_READY);
    w_viol[2]  = w_mrs && !w_cl_ok;
    w_viol[3]  = w_act && r_bank_act[i_ba];
    w_viol[4]  = w_rw && !r_bank_act[i_ba];
    w_viol[5]  = w_rw && r_bank_act[i_ba] && (r_act_age[i_ba] < RCD_A);
    w_viol[6]  = w_wr && ((|r_pv) || o_dq_oe);
    w_viol[7]  = (w_act && (r_pre_age[i_ba] < RP_A)) || (w_ref && w_pre_recent);
    w_viol[8]  = w_ref && (|r_bank_act);
    w_viol[9]  = w_any && (r_rfc_age < RFC_A);
    w_viol[10] = (r_state == ST_READY) && !w_ref && (r_ref_cnt >= REF_MAX);
    w_code = 4'd0;
    for (int k = 10; k >= 1; k--) begin
      if (w_viol[k]) w_code = 4'(k);
    end
  end

  // Array and read-data pipeline carry no reset so contents survive rst.
  always_ff @(posedge i_clk) begin
    r_pd[1] <= r_pd[2];
    r_pd[2] <= r_pd[3];
    if (w_rd) r_pd[r_cl] <= r_mem[w_idx];
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (!i_dm[i]) r_mem[w_idx][8*i +: 8] <= i_dq_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dq_o     <= '0;
      o_dq_oe    <= 1'b0;
      o_err      <= 1'b0;
      o_err_code <= 4'd0;
      r_bank_act <= '0;
      r_pv       <= '0;
      r_cl       <= 2'd3;
      r_rfc_age  <= AGE_MAX;
      r_ref_cnt  <= '0;
      for (int b = 0; b < 4; b++) begin
        r_act_age[b]  <= AGE_MAX;
        r_pre_age[b]  <= AGE_MAX;
        r_open_row[b] <= '0;
      end
    end else begin
      o_dq_oe <= r_pv[1];
      if (r_pv[1]) o_dq_o <= r_pd[1];
      r_pv <= {1'b0, r_pv[3:2]};
      if (w_rd) r_pv[r_cl] <= 1'b1;

      // Ages count cycles since the last event and saturate, so reset reads as "long ago".
      if (r_rfc_age != AGE_MAX) r_rfc_age <= r_rfc_age + AGE_ONE;
      if (w_ref) r_rfc_age <= AGE_ONE;
      for (int b = 0; b < 4; b++) begin
        if (r_act_age[b] != AGE_MAX) r_act_age[b] <= r_act_age[b] + AGE_ONE;
        if (r_pre_age[b] != AGE_MAX) r_pre_age[b] <= r_pre_age[b] + AGE_ONE;
        if (w_pre && (i_addr[10] || (2'(b) == i_ba)) && r_bank_act[b]) begin
          r_bank_act[b] <= 1'b0;
          r_pre_age[b]  <= AGE_ONE;
        end
      end
      if (w_act) begin
        r_bank_act[i_ba] <= 1'b1;
        r_open_row[i_ba] <= i_addr[MEM_ROW_BITS-1:0];
        r_act_age[i_ba]  <= AGE_ONE;
      end
      if (w_rw && i_addr[10]) begin
        r_bank_act[i_ba] <= 1'b0;
        r_pre_age[i_ba]  <= AGE_ONE;
      end
      if (w_mrs) r_cl <= w_cl_ok ? w_mrs_cl[1:0] : 2'd3;

      if (r_state != ST_READY || w_ref) r_ref_cnt <= '0;
      else if (r_ref_cnt != '1)        r_ref_cnt <= r_ref_cnt + 1'b1;

      if (!o_err && (w_code != 4'd0)) begin
        o_err      <= 1'b1;
        o_err_code <= w_code;
      end
    end
  end
endmodule

// File: tb/tb_sdram_device_model.sv
// tb/tb_sdram_device_model.sv - table-driven bench for sdram_device_model
module tb_sdram_device_model;
  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_MRS = 3'b000;

  logic        clk = 1'b0;
  logic        rst, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [10:0] addr;
  logic [3:0]  dm;
  logic [31:0] dq_i, dq_o;
  logic        dq_oe, ready, err;
  logic [3:0]  err_code;

  always #5 clk = ~clk;

  sdram_device_model dut (
    .i_clk(clk), .i_rst(rst), .i_cke(cke), .i_cs_n(cs_n), .i_ras_n(ras_n),
    .i_cas_n(cas_n), .i_we_n(we_n), .i_ba(ba), .i_addr(addr), .i_dm(dm),
    .i_dq_i(dq_i), .o_dq_o(dq_o), .o_dq_oe(dq_oe), .o_ready(ready),
    .o_err(err), .o_err_code(err_code)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [10:0] addr;
    logic [3:0]  dm;
    logic [31:0] dq;
    logic        chk;
    logic        exp_oe;
    logic        chk_dq;
    logic [31:0] exp_dq;
    logic        exp_ready;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic [2:0] c, input logic [1:0] b,
                     input logic [10:0] a, input logic [3:0] m, input logic [31:0] d,
                     input logic ck, input logic oe, input logic cd,
                     input logic [31:0] dqe, input logic rdy);
    vec_t e;
    e.rst = r; e.cmd = c; e.ba = b; e.addr = a; e.dm = m; e.dq = d;
    e.chk = ck; e.exp_oe = oe; e.chk_dq = cd; e.exp_dq = dqe; e.exp_ready = rdy;
    tbl.push_back(e);
  endtask

  task automatic step(input logic r, input logic [2:0] c, input logic [1:0] b,
                      input logic [10:0] a, input logic [3:0] m, input logic [31:0] d);
    rst = r; {ras_n, cas_n, we_n} = c; ba = b; addr = a; dm = m; dq_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(1'b0, C_NOP, 2'd0, 11'd0, 4'hF, 32'd0);
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [10:0] a);
    step(1'b0, c, b, a, 4'hF, 32'd0);
  endtask

  task automatic do_reset();
    step(1'b1, C_NOP, 2'd0, 11'd0, 4'hF, 32'd0);
  endtask

  task automatic do_init(input logic [10:0] mrs_addr);
    cmd(C_PRE, 2'd0, 11'h400);
    nop();
    cmd(C_REF, 2'd0, 11'd0);
    repeat (4) nop();
    cmd(C_REF, 2'd0, 11'd0);
    repeat (4) nop();
    cmd(C_MRS, 2'd0, mrs_addr);
  endtask

  task automatic chk_err(input string name, input logic e, input logic [3:0] code);
    chk({name, "_err"}, 32'(err), 32'(e));
    chk({name, "_code"}, 32'(err_code), 32'(code));
  endtask

  initial begin
    cke = 1'b1; cs_n = 1'b0; rst = 1'b1;
    {ras_n, cas_n, we_n} = C_NOP; ba = '0; addr = '0; dm = '1; dq_i = '0;

    // init, CL=3 write/read, byte masks, CL=2 back-to-back reads
    add(1, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 1, 32'h0, 0);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 1, 32'h0, 0);
    add(0, C_PRE, 0, 11'h400, 4'hF, 32'h0, 1, 0, 0, 32'h0, 0);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_REF, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_REF, 0, 11'h000, 4'hF, 32'h0, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 0, 32'h0, 0);
    add(0, C_MRS, 0, 11'h230, 4'hF, 32'h0, 1, 0, 1, 32'h0, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_ACT, 1, 11'h005, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_WR,  1, 11'h012, 4'h0, 32'hDEADBEEF, 1, 0, 0, 32'h0, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_RD,  1, 11'h012, 4'hF, 32'h0, 1, 0, 0, 32'h0, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 0, 32'h0, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 1, 32'h0, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 1, 1, 32'hDEADBEEF, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 1, 32'hDEADBEEF, 1);
    add(0, C_WR,  1, 11'h020, 4'h0, 32'h11223344, 0, 0, 0, 32'h0, 0);
    add(0, C_WR,  1, 11'h020, 4'h5, 32'hAABBCCDD, 0, 0, 0, 32'h0, 0);
    add(0, C_RD,  1, 11'h020, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 1, 32'hDEADBEEF, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 1, 1, 32'hAA22CC44, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 1, 32'hAA22CC44, 1);
    add(0, C_WR,  1, 11'h001, 4'h0, 32'h01010101, 0, 0, 0, 32'h0, 0);
    add(0, C_WR,  1, 11'h002, 4'h0, 32'h02020202, 0, 0, 0, 32'h0, 0);
    add(0, C_WR,  1, 11'h003, 4'h0, 32'h03030303, 0, 0, 0, 32'h0, 0);
    add(0, C_MRS, 0, 11'h020, 4'hF, 32'h0, 1, 0, 0, 32'h0, 1);
    add(0, C_RD,  1, 11'h001, 4'hF, 32'h0, 1, 0, 0, 32'h0, 1);
    add(0, C_RD,  1, 11'h002, 4'hF, 32'h0, 1, 0, 0, 32'h0, 1);
    add(0, C_RD,  1, 11'h003, 4'hF, 32'h0, 1, 1, 1, 32'h01010101, 1);
    add(0, C_RD,  1, 11'h012, 4'hF, 32'h0, 1, 1, 1, 32'h02020202, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 1, 1, 32'h03030303, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 1, 1, 32'hDEADBEEF, 1);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 1, 0, 1, 32'hDEADBEEF, 1);
    add(0, C_PRE, 1, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_NOP, 0, 11'h000, 4'hF, 32'h0, 0, 0, 0, 32'h0, 0);
    add(0, C_ACT, 1, 11'h005, 4'hF, 32'h0, 1, 0, 0, 32'h0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].cmd, tbl[i].ba, tbl[i].addr, tbl[i].dm, tbl[i].dq);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_oe", i), 32'(dq_oe), 32'(tbl[i].exp_oe));
        chk($sformatf("v%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
        chk($sformatf("v%0d_err", i), 32'(err), 32'd0);
        chk($sformatf("v%0d_code", i), 32'(err_code), 32'd0);
        if (tbl[i].chk_dq) chk($sformatf("v%0d_dq", i), dq_o, tbl[i].exp_dq);
      end
    end

    // READ one cycle after ACTIVE
    do_reset(); do_init(11'h230);
    cmd(C_ACT, 2'd0, 11'd0);
    cmd(C_RD, 2'd0, 11'd0);
    chk_err("rcd", 1'b1, 4'd5);

    // READ to idle bank; later ACTIVE-to-active must not overwrite the first code
    do_reset();
    chk_err("rst_clear", 1'b0, 4'd0);
    do_init(11'h230);
    cmd(C_RD, 2'd2, 11'd0);
    chk_err("idle_rd", 1'b1, 4'd4);
    cmd(C_ACT, 2'd2, 11'd0);
    cmd(C_ACT, 2'd2, 11'd0);
    chk_err("sticky", 1'b1, 4'd4);

    // ACTIVE before init completes
    do_reset();
    cmd(C_ACT, 2'd0, 11'd0);
    chk_err("pre_init", 1'b1, 4'd1);

    // illegal CAS latency
    do_reset(); do_init(11'h010);
    chk("bad_cl_ready", 32'(ready), 32'd1);
    chk_err("bad_cl", 1'b1, 4'd2);

    // ACTIVE one cycle after PRECHARGE
    do_reset(); do_init(11'h230);
    cmd(C_ACT, 2'd0, 11'd0);
    nop();
    cmd(C_PRE, 2'd0, 11'd0);
    cmd(C_ACT, 2'd0, 11'd0);
    chk_err("trp", 1'b1, 4'd7);

    // REFRESH with a bank open
    do_reset(); do_init(11'h230);
    cmd(C_ACT, 2'd3, 11'd0);
    nop(); nop();
    cmd(C_REF, 2'd0, 11'd0);
    chk_err("ref_open", 1'b1, 4'd8);

    // command inside T_RFC
    do_reset(); do_init(11'h230);
    cmd(C_REF, 2'd0, 11'd0);
    cmd(C_ACT, 2'd0, 11'd0);
    chk_err("trfc", 1'b1, 4'd9);

    // refresh watchdog: limit is 800 idle cycles after ready
    do_reset(); do_init(11'h230);
    repeat (800) nop();
    chk_err("refmax_edge", 1'b0, 4'd0);
    nop();
    chk_err("refmax", 1'b1, 4'd10);

    // reset with a read in flight
    do_reset(); do_init(11'h230);
    cmd(C_ACT, 2'd1, 11'h005);
    nop(); nop();
    cmd(C_RD, 2'd1, 11'h012);
    do_reset();
    chk("rst_rd_oe", 32'(dq_oe), 32'd0);
    chk("rst_rd_ready", 32'(ready), 32'd0);
    begin
      logic seen_oe;
      seen_oe = 1'b0;
      for (int i = 0; i < 4; i++) begin
        nop();
        seen_oe = seen_oe | dq_oe;
      end
      chk("rst_rd_flushed", 32'(seen_oe), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
